seq_check_scheduler: RTL

Round-robin scheduler that shares one bit-serial sequence detector between NREQ requesters. Each granted requester streams a fixed-length frame of FRAME_LEN bits through the detector. The scheduler clears the detector before each frame, counts its match pulses, and reports a per-frame match count tagged with the requester ID. It sits between the serial input lanes and the single detector instance.

---
 rtl/seq_check_scheduler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/seq_check_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : seq_check_scheduler
// Description : Round-robin scheduler sharing one bit-serial sequence
//               detector between NREQ requesters. Each grant streams one
//               FRAME_LEN-bit frame through the detector. Matches are counted
//               and reported with the requester ID.
//               Optional macro SEQ_ARB_ABORT_EN: dropping req mid-frame ends
//               the frame early and flags it as aborted.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_check_scheduler #(
    parameter int NREQ      = 4,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0]           bit_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      bit_ack,
    output logic                      det_x,
    output logic                      det_clr_n,
    input  logic                      det_out,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   done_id,
    output logic [CNT_W-1:0]          match_cnt,
    output logic                      aborted
);

    localparam int               ID_W     = $clog2(NREQ);
    localparam logic [7:0]       LAST_BIT = 8'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  arb_base;
    logic [ID_W-1:0]  arb_id;
    logic             arb_found;
    int               arb_idx;
    logic [7:0]       bit_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
`ifdef SEQ_ARB_ABORT_EN
    logic             abort_now;
`endif

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (int'(id) == NREQ - 1) ? '0 : id + ID_W'(1);
    endfunction

    // Circular search for the first active request at or after the base.
    // In REPORT the base already skips the requester just served.
    always_comb begin
        arb_found = 1'b0;
        arb_id    = '0;
        arb_idx   = 0;
        arb_base  = (state == REPORT) ? next_id(grant_id) : rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            arb_idx = int'(arb_base) + i;
            if (arb_idx >= NREQ) begin
                arb_idx = arb_idx - NREQ;
            end
            if (!arb_found && req[arb_idx]) begin
                arb_found = 1'b1;
                arb_id    = ID_W'(arb_idx);
            end
        end
    end

    // Next-state logic plus the two combinational outputs det_x and bit_ack.
    always_comb begin
        state_nxt = state;
        bit_ack   = 1'b0;
        det_x     = 1'b0;
`ifdef SEQ_ARB_ABORT_EN
        abort_now = 1'b0;
`endif
        case (state)
            IDLE:   if (arb_found) state_nxt = CLEAR;
            CLEAR:  state_nxt = STREAM;
            STREAM: begin
                bit_ack = 1'b1;
                det_x   = bit_in[grant_id];
                if (bit_cnt == LAST_BIT) state_nxt = DRAIN;
`ifdef SEQ_ARB_ABORT_EN
                if (!req[grant_id]) begin
                    abort_now = 1'b1;
                    state_nxt = REPORT;
                end
`endif
            end
            DRAIN:  state_nxt = REPORT;
            REPORT: state_nxt = arb_found ? CLEAR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Detector output is Moore, so the first STREAM cycle still shows the
    // cleared detector; DRAIN carries the response to the final bit.
    always_comb begin
        cnt_nxt = cnt;
        if (((state == STREAM) && (bit_cnt != '0)) || (state == DRAIN)) begin
            if (det_out && (cnt != CNT_MAX)) cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // State register, frame counters and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            bit_cnt  <= '0;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == CLEAR) grant_id <= arb_id;
            if (state == REPORT)    rr_ptr   <= next_id(grant_id);
            if (state == CLEAR)       bit_cnt <= '0;
            else if (state == STREAM) bit_cnt <= bit_cnt + 8'd1;
            cnt <= (state == CLEAR) ? '0 : cnt_nxt;
        end
    end

    // Registered grant and detector clear, both aligned with the CLEAR state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt       <= '0;
            det_clr_n <= 1'b1;
        end else begin
            det_clr_n <= (state_nxt != CLEAR);
            if (state_nxt == CLEAR)
                gnt <= NREQ'(1) << arb_id;
            else if ((state_nxt == REPORT) || (state_nxt == IDLE))
                gnt <= '0;
        end
    end

    // Frame report; done_id and match_cnt hold until the next report.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done      <= 1'b0;
            done_id   <= '0;
            match_cnt <= '0;
        end else begin
            done <= (state_nxt == REPORT);
            if (state_nxt == REPORT) begin
                done_id   <= grant_id;
                match_cnt <= cnt_nxt;
            end
        end
    end

`ifdef SEQ_ARB_ABORT_EN
    // Abort flag accompanies the done pulse of an early-terminated frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aborted <= 1'b0;
        end else if (state_nxt == REPORT) begin
            aborted <= abort_now;
        end else begin
            aborted <= 1'b0;
        end
    end
`else
    assign aborted = 1'b0;
`endif

endmodule
`default_nettype wire
